// File: rtl/alu_result_stage.sv
// Registered result stage behind the ALU units: opcode result select, Z/N/C/V flags,
// operand-a accumulator and a small valid/ready output FIFO.
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] or_result,
  input  logic [WIDTH-1:0] nor_result,
  input  logic [WIDTH-1:0] and_result,
  input  logic [WIDTH-1:0] nand_result,
  input  logic [WIDTH-1:0] xor_result,
  input  logic [WIDTH-1:0] xnor_result,
  input  logic [WIDTH-1:0] add_result,
  input  logic [WIDTH-1:0] sub_result,
  input  logic             add_carry,
  input  logic             sub_borrow,
  input  logic             add_ovf,
  input  logic             sub_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_err,
  output logic [WIDTH-1:0] acc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = WIDTH + 5;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) ptr_inc = '0;
    else                     ptr_inc = p + PW'(1);
  endfunction

  function automatic logic [3:0] calc_flags(input logic [WIDTH-1:0] res, input logic c,
                                            input logic v, input logic err);
    if (err) calc_flags = 4'b0000;
    else     calc_flags = {(res == '0), res[WIDTH-1], c, v};
  endfunction

  logic [EW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [EW-1:0]    r_head;
  logic [WIDTH-1:0] r_acc;

  logic [WIDTH-1:0] w_result;
  logic             w_c;
  logic             w_v;
  logic             w_err;
  logic [EW-1:0]    w_entry;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_acc_upd;
  logic [PW-1:0]    w_rd_next;
  logic [CW-1:0]    w_count_next;
  logic [EW-1:0]    w_head_next;

  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign {out_err, out_flags, out_result} = r_head;
  assign acc       = r_acc;

  assign w_accept  = in_valid & in_ready;
  assign w_push    = w_accept & (opcode != 4'd0);
  assign w_acc_upd = w_accept & (opcode >= 4'd1) & (opcode <= 4'd9);
  assign w_pop     = out_valid & out_ready;

  // Opcode result select and entry formation
  always_comb begin
    w_result = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_err    = 1'b0;
    case (opcode)
      4'd0: w_result = '0;
      4'd1: w_result = or_result;
      4'd2: w_result = nor_result;
      4'd3: w_result = and_result;
      4'd4: w_result = nand_result;
      4'd5: w_result = xor_result;
      4'd6: w_result = xnor_result;
      4'd7: begin w_result = add_result; w_c = add_carry;  w_v = add_ovf; end
      4'd8: begin w_result = sub_result; w_c = sub_borrow; w_v = sub_ovf; end
      4'd9: w_result = '0;
      default: w_err = 1'b1;
    endcase
    w_entry = {w_err, calc_flags(w_result, w_c, w_v, w_err), w_result};
  end

  // Next head: the incoming entry when it becomes the head this edge, else stored data
  always_comb begin
    if (w_pop) w_rd_next = ptr_inc(r_rd_ptr);
    else       w_rd_next = r_rd_ptr;
    if (w_push && (w_rd_next == r_wr_ptr)) w_head_next = w_entry;
    else                                   w_head_next = r_mem[w_rd_next];
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // FIFO, head register and accumulator state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_acc    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      if (w_count_next != '0) r_head <= w_head_next;
      if (w_acc_upd) r_acc <= w_result;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_alu_result_stage;

  typedef struct packed {
    logic        err;
    logic [3:0]  flags;
    logic [15:0] res;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [3:0]  opcode, out_flags;
  logic [15:0] or_r, nor_r, and_r, nand_r, xor_r, xnor_r, add_r, sub_r;
  logic        add_carry, sub_borrow, add_ovf, sub_ovf;
  logic [15:0] out_result, acc;

  int total = 0;
  int bad   = 0;

  entry_t      mq[$];
  entry_t      m_last;
  logic [15:0] m_acc;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .or_result(or_r), .nor_result(nor_r), .and_result(and_r), .nand_result(nand_r),
    .xor_result(xor_r), .xnor_result(xnor_r), .add_result(add_r), .sub_result(sub_r),
    .add_carry(add_carry), .sub_borrow(sub_borrow), .add_ovf(add_ovf), .sub_ovf(sub_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_err(out_err), .acc(acc)
  );

  function automatic entry_t model_entry();
    entry_t e;
    logic c, v;
    e = '0; c = 1'b0; v = 1'b0;
    if (opcode >= 4'd10) begin
      e.err = 1'b1;
      return e;
    end
    if      (opcode == 4'd1) e.res = or_r;
    else if (opcode == 4'd2) e.res = nor_r;
    else if (opcode == 4'd3) e.res = and_r;
    else if (opcode == 4'd4) e.res = nand_r;
    else if (opcode == 4'd5) e.res = xor_r;
    else if (opcode == 4'd6) e.res = xnor_r;
    else if (opcode == 4'd7) begin e.res = add_r; c = add_carry;  v = add_ovf; end
    else if (opcode == 4'd8) begin e.res = sub_r; c = sub_borrow; v = sub_ovf; end
    e.flags = {(e.res == 16'h0000), e.res[15], c, v};
    return e;
  endfunction

  // Advance one clock, updating the reference model from the inputs seen at the edge.
  task automatic step();
    entry_t e;
    bit acc_ok, pop_ok;
    if (rst) begin
      mq.delete();
      m_acc  = 16'h0000;
      m_last = '0;
    end else begin
      acc_ok = in_valid && (mq.size() < 2);
      pop_ok = (mq.size() != 0) && out_ready;
      e = model_entry();
      if (pop_ok) m_last = mq.pop_front();
      if (acc_ok && opcode != 4'd0) mq.push_back(e);
      if (acc_ok && opcode >= 4'd1 && opcode <= 4'd9) m_acc = e.res;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_units();
    logic [15:0] a, b;
    logic [16:0] s;
    a = 16'($urandom);
    b = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
    if ($urandom_range(0, 7) == 0) b = 16'h0000 - a;
    or_r = a | b;  nor_r  = ~(a | b);
    and_r = a & b; nand_r = ~(a & b);
    xor_r = a ^ b; xnor_r = ~(a ^ b);
    s = {1'b0, a} + {1'b0, b};
    add_r = s[15:0]; add_carry = s[16];
    add_ovf = (a[15] == b[15]) && (s[15] != a[15]);
    sub_r = a - b; sub_borrow = (a < b);
    sub_ovf = (a[15] != b[15]) && (sub_r[15] != a[15]);
  endtask

  task automatic test_reset();
    rand_units();
    out_ready = 1'b0; in_valid = 1'b1; opcode = 4'd3;
    step(); step();
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_prefill in_ready got=%b exp=0", in_ready); end
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL reset_state valid/ready got=%b%b exp=01", out_valid, in_ready);
    end
    total++;
    if ({acc, out_result, out_flags, out_err} !== 37'd0) begin
      bad++; $display("FAIL reset_values acc=%h res=%h flags=%b err=%b exp all zero", acc, out_result, out_flags, out_err);
    end
  endtask

  task automatic test_or();
    rand_units();
    or_r = 16'hF0F0; opcode = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_result, out_flags, acc} !== {1'b1, 16'hF0F0, 4'b0100, 16'hF0F0}) begin
      bad++; $display("FAIL or_path valid=%b res=%h flags=%b acc=%h exp 1 f0f0 0100 f0f0", out_valid, out_result, out_flags, acc);
    end
  endtask

  task automatic test_add();
    rand_units();
    add_r = 16'h0000; add_carry = 1'b1; add_ovf = 1'b0; opcode = 4'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_result, out_flags} !== {1'b1, 16'h0000, 4'b1010}) begin
      bad++; $display("FAIL add_carry_zero valid=%b res=%h flags=%b exp 1 0000 1010", out_valid, out_result, out_flags);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1;
    rand_units(); nor_r = 16'h0F0F; opcode = 4'd2;
    step();
    rand_units(); sub_r = 16'h8000; sub_borrow = 1'b0; sub_ovf = 1'b1; opcode = 4'd8;
    step();
    total++;
    if ({in_ready, acc} !== {1'b0, 16'h8000}) begin
      bad++; $display("FAIL bp_full in_ready=%b acc=%h exp 0 8000", in_ready, acc);
    end
    rand_units(); or_r = 16'h1111; opcode = 4'd1;
    step();
    total++;
    if ({in_ready, acc, out_result, out_flags} !== {1'b0, 16'h8000, 16'h0F0F, 4'b0000}) begin
      bad++; $display("FAIL bp_ignored in_ready=%b acc=%h res=%h flags=%b exp 0 8000 0f0f 0000", in_ready, acc, out_result, out_flags);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    total++;
    if ({out_valid, out_result, out_flags} !== {1'b1, 16'h8000, 4'b0101}) begin
      bad++; $display("FAIL bp_second valid=%b res=%h flags=%b exp 1 8000 0101", out_valid, out_result, out_flags);
    end
    step();
    total++;
    if ({out_valid, out_result, out_flags} !== {1'b0, 16'h8000, 4'b0101}) begin
      bad++; $display("FAIL bp_hold_empty valid=%b res=%h flags=%b exp 0 8000 0101", out_valid, out_result, out_flags);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1;
    rand_units(); xor_r = 16'h00FF; opcode = 4'd5;
    step();
    rand_units(); and_r = 16'h1234; opcode = 4'd3; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, in_ready, out_result, acc} !== {1'b1, 1'b1, 16'h1234, 16'h1234}) begin
      bad++; $display("FAIL push_pop valid=%b ready=%b res=%h acc=%h exp 1 1 1234 1234", out_valid, in_ready, out_result, acc);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL push_pop_drain out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_illegal_nop();
    rand_units(); opcode = 4'd12; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_err, out_result, out_flags, acc} !== {1'b1, 1'b1, 16'h0000, 4'b0000, 16'h1234}) begin
      bad++; $display("FAIL illegal valid=%b err=%b res=%h flags=%b acc=%h exp 1 1 0000 0000 1234", out_valid, out_err, out_result, out_flags, acc);
    end
    step();
    rand_units(); opcode = 4'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({out_valid, in_ready, acc} !== {1'b0, 1'b1, 16'h1234}) begin
        bad++; $display("FAIL nop cyc=%0d valid=%b ready=%b acc=%h exp 0 1 1234", i, out_valid, in_ready, acc);
      end
      step();
    end
  endtask

  task automatic test_random();
    entry_t exp_head;
    for (int n = 0; n < 400; n++) begin
      rand_units();
      rst       = ($urandom_range(0, 63) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      opcode    = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      step();
      exp_head = (mq.size() != 0) ? mq[0] : m_last;
      total++;
      if ({out_valid, in_ready, acc} !== {(mq.size() != 0), (mq.size() < 2), m_acc}) begin
        bad++; $display("FAIL rand_ctrl n=%0d valid=%b ready=%b acc=%h exp %b %b %h", n,
                        out_valid, in_ready, acc, (mq.size() != 0), (mq.size() < 2), m_acc);
      end
      total++;
      if ({out_err, out_flags, out_result} !== exp_head) begin
        bad++; $display("FAIL rand_head n=%0d got err=%b flags=%b res=%h exp err=%b flags=%b res=%h", n,
                        out_err, out_flags, out_result, exp_head.err, exp_head.flags, exp_head.res);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = 4'd0;
    rand_units();
    @(negedge clk);
    step();
    rst = 1'b0;
    test_reset();
    test_or();
    test_add();
    test_backpressure();
    test_back_to_back();
    test_illegal_nop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 16-bit bitwise and arithmetic ALU units (OR, NOR, AND, NAND, XOR, XNOR, ADD, SUB).
- Selects the unit result named by opcode and computes status flags.
- Updates an accumulator that feeds back as the ALU's operand a.
- Buffers results in a 2-entry FIFO with a valid/ready handshake toward the consumer (register file / display).

Parameters:
- WIDTH, 16, data width of every ALU result and of the accumulator.
- DEPTH, 2, FIFO entries; the design is only required to support 2.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an opcode plus unit results this cycle.
- in_ready  output  1  stage can accept; equals (count < DEPTH).
- opcode  input  4  operation select (encoding below).
- or_result, nor_result, and_result, nand_result, xor_result, xnor_result, add_result, sub_result  input  WIDTH each  unit outputs.
- add_carry, sub_borrow  input  1 each  carry out of ADD, borrow out of SUB.
- add_ovf, sub_ovf  input  1 each  signed overflow of ADD, SUB.
- out_valid  output  1  FIFO head valid; equals (count != 0).
- out_ready  input  1  consumer accepts head.
- out_result  output  WIDTH  head result.
- out_flags  output  4  head flags {Z, N, C, V}.
- out_err  output  1  head was an illegal opcode.
- acc  output  WIDTH  accumulator, operand-a feedback to the ALU.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, rst; it is sampled only on the clk rising edge.
- Reset values: count=0, FIFO storage=0, acc=0. out_valid=0, out_result=0, out_flags=0, out_err=0, in_ready=1.
- rst asserted mid-operation discards all buffered entries on that edge. Handshakes in that cycle have no effect.
- Accept (push) = in_valid & in_ready. Pop = out_valid & out_ready.
- Opcode encoding:
  - 0 NOP: consumed; no FIFO entry; acc unchanged.
  - 1 OR, 2 NOR, 3 AND, 4 NAND, 5 XOR, 6 XNOR, 7 ADD, 8 SUB.
  - 9 CLR: result 0; acc=0.
  - 10-15 illegal: result 0, flags 0, err=1; acc unchanged.
- Flags, computed from the selected result:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - C = add_carry for ADD, sub_borrow for SUB, else 0.
  - V = add_ovf for ADD, sub_ovf for SUB, else 0.
  - CLR gives Z=1, N=0, C=0, V=0.
- Accumulator: on accept of opcodes 1-9, acc <= selected result on the same edge. acc is independent of pop and of FIFO occupancy.
- Latency: an entry accepted at edge k is visible at out_* after edge k (out_valid=1 in cycle k+1) when the FIFO was empty.
- No combinational path from in_* to out_*.
- in_ready depends only on registered count. There is no path from out_ready to in_ready, so a full FIFO refuses input even when popping that cycle.
- FIFO: order preserved. Read pointer and write pointer wrap modulo DEPTH. Count update:
  - push only: count+1.
  - pop only: count-1.
  - push & pop (count=1): count stays 1; new entry lands behind the head.
  - push & pop at count=0 cannot occur (out_valid=0).
- Full (count=2): in_ready=0; in_valid ignored; acc not updated.
- Empty: out_result/out_flags/out_err hold the last popped values; the consumer must qualify them with out_valid.
- NOP accepted while full: impossible (in_ready=0). NOP accepted otherwise: count unchanged.
- Head out_* values are stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset: drive rst=1 one cycle with FIFO holding 2 entries -> next cycle count=0, out_valid=0, in_ready=1, acc=0x0000.
- OR path: opcode=1, or_result=0xF0F0, out_ready=1 -> out_valid=1 one cycle later, out_result=0xF0F0, flags={0,1,0,0}, acc=0xF0F0.
- ADD carry/zero: opcode=7, add_result=0x0000, add_carry=1, add_ovf=0 -> out_result=0x0000, flags={1,0,1,0}.
- Backpressure: out_ready=0, push NOR (0x0F0F) then SUB (0x8000, sub_ovf=1) -> in_ready=0 after second push; a third in_valid is ignored with acc=0x8000. Raise out_ready -> pops 0x0F0F flags{0,0,0,0}, then 0x8000 flags{0,1,0,1}, in order.
- Simultaneous push/pop at count=1: head XOR 0x00FF, push AND 0x1234 with out_ready=1 -> count stays 1, next head 0x1234.
- Illegal and NOP: opcode=12 -> out_err=1, out_result=0, acc unchanged. Opcode=0 accepted -> no out_valid pulse, acc unchanged.
